fg_burst_sched: RTL

Flow generator burst scheduler: sits downstream of the burst descriptor FIFO and converts each burst descriptor (destination, byte length) into a sequence of frame descriptors no longer than a runtime maximum frame length. It enforces a programmable idle gap between bursts and feeds the frame generator, which builds the actual frames.

---
 rtl/fg_burst_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fg_burst_sched.sv
// fg_burst_sched: converts burst descriptors (dest, byte length) into frame
// descriptors of at most max_frame_len bytes, then holds off the next burst
// for ifg_cycles idle cycles.
// Optional feature macro: FG_BURST_SCHED_STATS_EN adds the burst_count and
// frame_count statistics outputs.
module fg_burst_sched #(
  parameter int unsigned DEST_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_bd_valid,
  output logic                  input_bd_ready,
  input  logic [DEST_WIDTH-1:0] input_bd_dest,
  input  logic [31:0]           input_bd_burst_len,
  output logic                  output_fd_valid,
  input  logic                  output_fd_ready,
  output logic [DEST_WIDTH-1:0] output_fd_dest,
  output logic [LEN_WIDTH-1:0]  output_fd_len,
  output logic                  output_fd_last,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  max_frame_len,
  input  logic [15:0]           ifg_cycles,
  output logic                  busy
`ifdef FG_BURST_SCHED_STATS_EN
  ,
  output logic [31:0]           burst_count,
  output logic [31:0]           frame_count
`endif
);

  localparam int unsigned REM_W = 32;
  localparam int unsigned GAP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DEST_WIDTH-1:0] dest_q,  dest_d;
  logic [REM_W-1:0]      rem_q,   rem_d;
  logic [LEN_WIDTH-1:0]  max_q,   max_d;
  logic [LEN_WIDTH-1:0]  len_q,   len_d;
  logic                  last_q,  last_d;
  logic                  valid_q, valid_d;
  logic [GAP_W-1:0]      gap_q,   gap_d;
  logic                  busy_q,  busy_d;
`ifdef FG_BURST_SCHED_STATS_EN
  logic [31:0]           bcnt_q,  bcnt_d;
  logic [31:0]           fcnt_q,  fcnt_d;
`endif

  logic [LEN_WIDTH-1:0]  eff_max;
  logic [REM_W-1:0]      rem_after;
  logic                  fd_hs;

  // Frame length for a given remaining byte count (zero-extended compare).
  function automatic logic [LEN_WIDTH-1:0] frame_len(input logic [REM_W-1:0]     rem,
                                                     input logic [LEN_WIDTH-1:0] mx);
    frame_len = (rem <= REM_W'(mx)) ? rem[LEN_WIDTH-1:0] : mx;
  endfunction

  // A frame is the last of its burst when everything left fits in it.
  function automatic logic frame_last(input logic [REM_W-1:0]     rem,
                                      input logic [LEN_WIDTH-1:0] mx);
    frame_last = (rem <= REM_W'(mx));
  endfunction

  // Zero max_frame_len selects the largest representable frame.
  assign eff_max   = (max_frame_len == '0) ? '1 : max_frame_len;
  assign rem_after = rem_q - REM_W'(len_q);
  assign fd_hs     = valid_q & output_fd_ready;

  // Acceptance is the only combinational output; it depends on state and enable only.
  assign input_bd_ready = (state_q == ST_IDLE) & enable;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      rem_q   <= '0;
      max_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
`ifdef FG_BURST_SCHED_STATS_EN
      bcnt_q  <= '0;
      fcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      rem_q   <= rem_d;
      max_q   <= max_d;
      len_q   <= len_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
`ifdef FG_BURST_SCHED_STATS_EN
      bcnt_q  <= bcnt_d;
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  // Next-state logic: accept, split into frames, then count down the gap.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    rem_d   = rem_q;
    max_d   = max_q;
    len_d   = len_q;
    last_d  = last_q;
    valid_d = valid_q;
    gap_d   = gap_q;
`ifdef FG_BURST_SCHED_STATS_EN
    bcnt_d  = bcnt_q;
    fcnt_d  = fcnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (input_bd_valid && enable) begin
          dest_d = input_bd_dest;
          rem_d  = input_bd_burst_len;
          max_d  = eff_max;
          if (input_bd_burst_len != '0) begin
            len_d   = frame_len(input_bd_burst_len, eff_max);
            last_d  = frame_last(input_bd_burst_len, eff_max);
            valid_d = 1'b1;
            state_d = ST_ACTIVE;
`ifdef FG_BURST_SCHED_STATS_EN
            bcnt_d  = bcnt_q + 32'd1;
`endif
          end
        end
      end

      ST_ACTIVE: begin
        if (fd_hs) begin
          rem_d = rem_after;
`ifdef FG_BURST_SCHED_STATS_EN
          fcnt_d = fcnt_q + 32'd1;
`endif
          if (last_q) begin
            valid_d = 1'b0;
            gap_d   = ifg_cycles;
            state_d = (ifg_cycles == '0) ? ST_IDLE : ST_GAP;
          end else begin
            len_d  = frame_len(rem_after, max_q);
            last_d = frame_last(rem_after, max_q);
          end
        end
      end

      ST_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign output_fd_valid = valid_q;
  assign output_fd_dest  = dest_q;
  assign output_fd_len   = len_q;
  assign output_fd_last  = last_q;
  assign busy            = busy_q;
`ifdef FG_BURST_SCHED_STATS_EN
  assign burst_count     = bcnt_q;
  assign frame_count     = fcnt_q;
`endif

endmodule
